// File: rtl/fe_capture_multi.sv
// Multi-channel front-end capture engine: per-channel one-entry pending slots drained
// round-robin into a single FIFO write stream of {channel, command, delta time} records.
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 3
`endif

module fe_capture_multi #(
  parameter int pCHANNELS             = 4,
  parameter int pCH_BITS              = 2,
  parameter int pCMD_WIDTH            = 2,
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pCAPTURE_LEN_WIDTH    = 24
) (
  input  logic                               fe_clk,
  input  logic                               reset_n,
  input  logic [pCHANNELS-1:0]               I_event,
  input  logic [pCHANNELS*pCMD_WIDTH-1:0]    I_data_cmd,
  input  logic                               I_arm,
  input  logic                               I_capture_enable,
  input  logic [pCAPTURE_LEN_WIDTH-1:0]      I_capture_len,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0]   I_max_timestamp,
  input  logic                               I_timestamps_disable,
  input  logic                               I_fifo_full,
  output logic                               O_fifo_wr,
  output logic [pCH_BITS-1:0]                O_fifo_channel,
  output logic [pCMD_WIDTH-1:0]              O_fifo_command,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0]   O_fifo_time,
  output logic                               O_capturing,
  output logic                               O_capture_done,
  output logic [pCHANNELS-1:0]               O_drop,
  output logic [pCAPTURE_LEN_WIDTH-1:0]      O_write_count,
  output logic [1:0]                         O_state
);

  localparam logic [pCMD_WIDTH-1:0] CMD_TIME = pCMD_WIDTH'(`FE_FIFO_CMD_TIME);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                                 state_q, state_d;
  logic                                   arm_q;
  logic [pCHANNELS-1:0]                   pend_q;
  logic [pCHANNELS-1:0][pCMD_WIDTH-1:0]   cmd_q;
  logic [pCHANNELS-1:0]                   drop_q;
  logic [pCH_BITS-1:0]                    rr_q;
  logic [pTIMESTAMP_FULL_WIDTH-1:0]       ts_q;
  logic [pCAPTURE_LEN_WIDTH-1:0]          count_q;

  logic                                   arm_rise;
  logic                                   count_ok;
  logic                                   can_write;
  logic                                   sampling;
  logic                                   grant_any;
  logic [pCH_BITS-1:0]                    grant_idx;
  logic                                   lo_any, hi_any;
  logic [pCH_BITS-1:0]                    lo_idx, hi_idx;
  logic [pCHANNELS-1:0]                   grant_vec;
  logic                                   time_write;
  logic                                   do_write;

  assign arm_rise  = I_arm & ~arm_q;
  assign count_ok  = (I_capture_len == '0) || (count_q < I_capture_len);
  assign can_write = (state_q == ST_CAPTURE) && !arm_rise && !I_fifo_full && count_ok;
  assign sampling  = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

  // Round-robin: prefer the lowest pending channel at/above rr_q, else wrap to the lowest overall.
  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
    hi_any = 1'b0;
    hi_idx = '0;
    for (int i = pCHANNELS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_any = 1'b1;
        lo_idx = pCH_BITS'(i);
        if (i >= int'(rr_q)) begin
          hi_any = 1'b1;
          hi_idx = pCH_BITS'(i);
        end
      end
    end
    grant_any = can_write && lo_any;
    grant_idx = hi_any ? hi_idx : lo_idx;
    grant_vec = '0;
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  assign time_write = can_write && !lo_any && !I_timestamps_disable &&
                      (ts_q == I_max_timestamp);
  assign do_write   = grant_any || time_write;

  always_comb begin
    state_d = state_q;
    if (arm_rise) begin
      state_d = ST_ARMED;
    end else begin
      unique case (state_q)
        ST_ARMED:   if (I_capture_enable) state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          if (!I_capture_enable)
            state_d = ST_ARMED;
          else if ((I_capture_len != '0) && (count_q == I_capture_len))
            state_d = ST_DONE;
        end
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= I_arm;
    end
  end

  // A granted slot re-hit on the same edge is refilled; an ungranted re-hit is an overrun.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      cmd_q  <= '0;
      drop_q <= '0;
    end else if (arm_rise) begin
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < pCHANNELS; i++) begin
        if (sampling && I_event[i]) begin
          if (pend_q[i] && !grant_vec[i]) begin
            drop_q[i] <= 1'b1;
          end else begin
            pend_q[i] <= 1'b1;
            cmd_q[i]  <= I_data_cmd[i*pCMD_WIDTH +: pCMD_WIDTH];
          end
        end else if (grant_vec[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q    <= '0;
      ts_q    <= pTIMESTAMP_FULL_WIDTH'(1);
      count_q <= '0;
    end else begin
      if (grant_any)
        rr_q <= (grant_idx == pCH_BITS'(pCHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      if (arm_rise || do_write)
        ts_q <= pTIMESTAMP_FULL_WIDTH'(1);
      else if (state_q == ST_CAPTURE)
        ts_q <= (ts_q >= I_max_timestamp) ? I_max_timestamp : ts_q + 1'b1;
      if (arm_rise)
        count_q <= '0;
      else if (do_write)
        count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      O_fifo_wr      <= 1'b0;
      O_fifo_channel <= '0;
      O_fifo_command <= '0;
      O_fifo_time    <= '0;
    end else begin
      O_fifo_wr <= do_write;
      if (grant_any) begin
        O_fifo_channel <= grant_idx;
        O_fifo_command <= cmd_q[grant_idx];
        O_fifo_time    <= I_timestamps_disable ? '0 : ts_q;
      end else if (time_write) begin
        O_fifo_channel <= '0;
        O_fifo_command <= CMD_TIME;
        O_fifo_time    <= ts_q;
      end
    end
  end

  assign O_capturing    = (state_q == ST_CAPTURE);
  assign O_capture_done = (state_q == ST_DONE);
  assign O_drop         = drop_q;
  assign O_write_count  = count_q;
  assign O_state        = state_q;

endmodule
